// File: rtl/xform_batch_sequencer_if.sv
// Host/transform-stage bundle for xform_batch_sequencer.
// master = host + transform stage side, slave = sequencer side.
interface xform_batch_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int AW         = 3
);
    logic                    load_valid;
    logic [DATA_WIDTH-1:0]   load_x;
    logic [DATA_WIDTH-1:0]   load_y;
    logic                    load_ready;
    logic                    batch_go;
    logic                    xf_start;
    logic [DATA_WIDTH-1:0]   xf_x;
    logic [DATA_WIDTH-1:0]   xf_y;
    logic                    xf_valid;
    logic [2*DATA_WIDTH-1:0] xf_combined;
    logic [AW-1:0]           rd_addr;
    logic [2*DATA_WIDTH-1:0] rd_data;
    logic [AW:0]             count;
    logic                    busy;
    logic                    batch_done;
    logic                    timeout_err;

    modport master (
        output load_valid, load_x, load_y, batch_go, xf_valid, xf_combined, rd_addr,
        input  load_ready, xf_start, xf_x, xf_y, rd_data, count, busy, batch_done, timeout_err
    );

    modport slave (
        input  load_valid, load_x, load_y, batch_go, xf_valid, xf_combined, rd_addr,
        output load_ready, xf_start, xf_x, xf_y, rd_data, count, busy, batch_done, timeout_err
    );
endinterface

// File: rtl/xform_batch_sequencer.sv
// Buffers a batch of points and issues them one at a time to the 2D transform stage.
// Optional WAIT timeout enabled by defining SEQ_TIMEOUT_EN.
module xform_batch_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH       = 8,
    parameter int AW          = 3,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    xform_batch_sequencer_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    if ((DEPTH != (1 << AW)) || (DEPTH < 2) || (TIMEOUT_CYC < 1)) begin : g_param_bad
        $error("xform_batch_sequencer: inconsistent DEPTH/AW/TIMEOUT_CYC");
    end

    state_t             state_r, next_state_s;
    logic [AW:0]        count_r;
    logic [AW-1:0]      idx_r;
    logic [2*DW-1:0]    in_buf_r  [DEPTH];
    logic [2*DW-1:0]    res_buf_r [DEPTH];
    logic               xf_start_r, busy_r, batch_done_r;
    logic [DW-1:0]      xf_x_r, xf_y_r;
    logic [2*DW-1:0]    rd_data_r;

    logic               load_ready_s, load_acc_s, last_s, resp_s, tmo_hit_s;
    logic               go_acc_s, res_we_s, adv_s;
    logic [AW:0]        count_eff_s;
    logic [AW-1:0]      idx_nx_s;
    logic [2*DW-1:0]    op_s, res_data_s;

    assign load_ready_s = (state_r == IDLE) && (count_r < DEPTH_C);
    assign load_acc_s   = bus.load_valid && load_ready_s;
    // A load accepted alongside batch_go joins the batch being started.
    assign count_eff_s  = count_r + {{AW{1'b0}}, load_acc_s};
    assign idx_nx_s     = idx_r + AW'(1);
    assign last_s       = ({1'b0, idx_r} == (count_r - ONE_C));
    assign resp_s       = bus.xf_valid || tmo_hit_s;
    assign res_data_s   = bus.xf_valid ? bus.xf_combined : {(2*DW){1'b0}};

    // Next-state and per-cycle control decode.
    always_comb begin
        next_state_s = state_r;
        go_acc_s     = 1'b0;
        res_we_s     = 1'b0;
        adv_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.batch_go) begin
                    go_acc_s = 1'b1;
                    if (count_eff_s != {(AW+1){1'b0}}) begin
                        next_state_s = ISSUE;
                    end else begin
                        next_state_s = DONE;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE: next_state_s = WAIT;
            WAIT: begin
                if (resp_s) begin
                    res_we_s = 1'b1;
                    if (last_s) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = ISSUE;
                        adv_s        = 1'b1;
                    end
                end else begin
                    next_state_s = WAIT;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Operand for the ISSUE cycle being entered; bypasses a same-cycle load into slot 0.
    always_comb begin
        op_s = in_buf_r[{AW{1'b0}}];
        if (state_r == WAIT) begin
            op_s = in_buf_r[idx_nx_s];
        end else if (load_acc_s && (count_r == {(AW+1){1'b0}})) begin
            op_s = {bus.load_y, bus.load_x};
        end else begin
            op_s = in_buf_r[{AW{1'b0}}];
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            count_r      <= {(AW+1){1'b0}};
            idx_r        <= {AW{1'b0}};
            xf_start_r   <= 1'b0;
            xf_x_r       <= {DW{1'b0}};
            xf_y_r       <= {DW{1'b0}};
            busy_r       <= 1'b0;
            batch_done_r <= 1'b0;
            rd_data_r    <= {(2*DW){1'b0}};
        end else begin
            state_r <= next_state_s;
            if (state_r == DONE) begin
                count_r <= {(AW+1){1'b0}};
            end else if (load_acc_s) begin
                count_r <= count_r + ONE_C;
            end
            if (go_acc_s) begin
                idx_r <= {AW{1'b0}};
            end else if (adv_s) begin
                idx_r <= idx_nx_s;
            end
            xf_start_r <= (next_state_s == ISSUE);
            if (next_state_s == ISSUE) begin
                {xf_y_r, xf_x_r} <= op_s;
            end
            busy_r       <= (next_state_s != IDLE);
            batch_done_r <= (next_state_s == DONE);
            rd_data_r    <= res_buf_r[bus.rd_addr];
        end
    end

    // Point and result storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (load_acc_s) begin
            in_buf_r[count_r[AW-1:0]] <= {bus.load_y, bus.load_x};
        end
        if (res_we_s) begin
            res_buf_r[idx_r] <= res_data_s;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wait_cnt_r;
    logic          timeout_err_r;

    assign tmo_hit_s = (state_r == WAIT) && !bus.xf_valid &&
                       (wait_cnt_r == TW'(TIMEOUT_CYC - 1));

    // WAIT-cycle counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r    <= {TW{1'b0}};
            timeout_err_r <= 1'b0;
        end else begin
            if (state_r == ISSUE) begin
                wait_cnt_r <= {TW{1'b0}};
            end else if (state_r == WAIT) begin
                wait_cnt_r <= wait_cnt_r + TW'(1);
            end
            if (tmo_hit_s) begin
                timeout_err_r <= 1'b1;
            end else if (go_acc_s) begin
                timeout_err_r <= 1'b0;
            end
        end
    end

    assign bus.timeout_err = timeout_err_r;
`else
    assign tmo_hit_s       = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.load_ready = load_ready_s;
    assign bus.xf_start   = xf_start_r;
    assign bus.xf_x       = xf_x_r;
    assign bus.xf_y       = xf_y_r;
    assign bus.rd_data    = rd_data_r;
    assign bus.count      = count_r;
    assign bus.busy       = busy_r;
    assign bus.batch_done = batch_done_r;
endmodule

// File: tb/tb_xform_batch_sequencer.sv
// Directed bench for xform_batch_sequencer; the transform stage is modelled inline.
module tb_xform_batch_sequencer;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   start_cnt;
    int   done_cnt;
    int   s0;
    int   d0;

    xform_batch_sequencer_if #(.DATA_WIDTH(16), .AW(3)) bus ();

    xform_batch_sequencer #(
        .DATA_WIDTH(16), .DEPTH(8), .AW(3), .TIMEOUT_CYC(15)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.xf_start)   start_cnt <= start_cnt + 1;
        if (bus.batch_done) done_cnt  <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [15:0] x, input logic [15:0] y);
        bus.load_valid = 1'b1;
        bus.load_x     = x;
        bus.load_y     = y;
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic read_res(input logic [2:0] a, input logic [31:0] exp, input string tag);
        bus.rd_addr = a;
        tick();
        chk(tag, bus.rd_data, exp);
    endtask

    // Wait (bounded) for an ISSUE cycle, answer {y+1,x+1} lat cycles later.
    task automatic run_point(input logic [15:0] ex, input logic [15:0] ey,
                             input int lat, input bit stray);
        int n;
        n = 0;
        while (!bus.xf_start && n < 30) begin
            tick();
            n++;
        end
        chk("start_seen", {31'd0, bus.xf_start}, 32'd1);
        chk("issue_x", {16'd0, bus.xf_x}, {16'd0, ex});
        chk("issue_y", {16'd0, bus.xf_y}, {16'd0, ey});
        for (int i = 0; i < lat; i++) begin
            if (i == 0 && stray) begin
                bus.xf_valid    = 1'b1;
                bus.xf_combined = 32'hDEADBEEF;
            end
            tick();
            bus.xf_valid = 1'b0;
            chk("wait_nostart", {31'd0, bus.xf_start}, 32'd0);
            chk("wait_hold", {bus.xf_y, bus.xf_x}, {ey, ex});
        end
        bus.xf_valid    = 1'b1;
        bus.xf_combined = {ey + 16'd1, ex + 16'd1};
        tick();
        bus.xf_valid = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0; start_cnt = 0; done_cnt = 0;
        rst_n = 1'b0;
        bus.load_valid = 1'b0; bus.load_x = 16'd0; bus.load_y = 16'd0;
        bus.batch_go = 1'b0; bus.xf_valid = 1'b0; bus.xf_combined = 32'd0;
        bus.rd_addr = 3'd0;
        tick(); tick();
        chk("rst_start", {31'd0, bus.xf_start}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.batch_done}, 32'd0);
        chk("rst_count", {28'd0, bus.count}, 32'd0);
        chk("rst_rd", bus.rd_data, 32'd0);
        chk("rst_xy", {bus.xf_y, bus.xf_x}, 32'd0);
        chk("rst_tmo", {31'd0, bus.timeout_err}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", {31'd0, bus.load_ready}, 32'd1);

        // Basic 3-point batch, latency 3
        load(16'd1, 16'd2);
        load(16'd3, 16'd4);
        load(16'hFFFB, 16'd6);
        chk("b1_count", {28'd0, bus.count}, 32'd3);
        bus.batch_go = 1'b1;
        tick();
        bus.batch_go = 1'b0;
        chk("b1_busy", {31'd0, bus.busy}, 32'd1);
        chk("b1_notready", {31'd0, bus.load_ready}, 32'd0);
        run_point(16'd1, 16'd2, 3, 1'b0);
        run_point(16'd3, 16'd4, 3, 1'b0);
        run_point(16'hFFFB, 16'd6, 3, 1'b0);
        chk("b1_done", {31'd0, bus.batch_done}, 32'd1);
        tick();
        chk("b1_done_pulse", {31'd0, bus.batch_done}, 32'd0);
        chk("b1_idle", {31'd0, bus.busy}, 32'd0);
        chk("b1_count0", {28'd0, bus.count}, 32'd0);
        chk("b1_starts", start_cnt, 32'd3);
        chk("b1_dones", done_cnt, 32'd1);
        read_res(3'd0, 32'h0003_0002, "b1_res0");
        read_res(3'd1, 32'h0005_0004, "b1_res1");
        read_res(3'd2, 32'h0007_FFFC, "b1_res2");

        // Overfill: 10 points offered, only 8 taken
        bus.load_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.load_x = 16'(i);
            bus.load_y = 16'(100 + i);
            tick();
        end
        bus.load_valid = 1'b0;
        chk("ovf_count", {28'd0, bus.count}, 32'd8);
        chk("ovf_ready", {31'd0, bus.load_ready}, 32'd0);
        s0 = start_cnt;
        bus.batch_go = 1'b1;
        tick();
        bus.batch_go = 1'b0;
        for (int i = 0; i < 8; i++) begin
            run_point(16'(i), 16'(100 + i), 1, 1'b0);
        end
        chk("ovf_done", {31'd0, bus.batch_done}, 32'd1);
        tick();
        chk("ovf_starts", start_cnt - s0, 32'd8);
        read_res(3'd7, 32'h006C_0008, "ovf_res7");

        // Empty batch
        s0 = start_cnt;
        bus.batch_go = 1'b1;
        tick();
        bus.batch_go = 1'b0;
        chk("empty_busy", {31'd0, bus.busy}, 32'd1);
        chk("empty_done", {31'd0, bus.batch_done}, 32'd1);
        chk("empty_nostart", {31'd0, bus.xf_start}, 32'd0);
        tick();
        chk("empty_busy_off", {31'd0, bus.busy}, 32'd0);
        chk("empty_done_off", {31'd0, bus.batch_done}, 32'd0);
        chk("empty_starts", start_cnt - s0, 32'd0);

        // Stray valid in IDLE and ISSUE; load accepted together with batch_go
        bus.xf_valid = 1'b1;
        bus.xf_combined = 32'hDEADBEEF;
        tick();
        bus.xf_valid = 1'b0;
        read_res(3'd0, 32'h0065_0001, "stray_idle");
        load(16'd10, 16'd20);
        bus.load_valid = 1'b1;
        bus.load_x = 16'd30;
        bus.load_y = 16'd40;
        bus.batch_go = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        bus.batch_go = 1'b0;
        run_point(16'd10, 16'd20, 3, 1'b1);
        run_point(16'd30, 16'd40, 2, 1'b0);
        chk("stray_done", {31'd0, bus.batch_done}, 32'd1);
        tick();
        read_res(3'd0, 32'h0015_000B, "stray_res0");
        read_res(3'd1, 32'h0029_001F, "stray_res1");

        // Reset during WAIT of point 1 of 4
        for (int i = 0; i < 4; i++) load(16'(50 + i), 16'(60 + i));
        bus.batch_go = 1'b1;
        tick();
        bus.batch_go = 1'b0;
        run_point(16'd50, 16'd60, 1, 1'b0);
        chk("mid_issue1", {31'd0, bus.xf_start}, 32'd1);
        tick();
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("mid_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_xy", {bus.xf_y, bus.xf_x}, 32'd0);
        chk("mid_count", {28'd0, bus.count}, 32'd0);
        chk("mid_rd", bus.rd_data, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_ready", {31'd0, bus.load_ready}, 32'd1);
        tick(); tick();
        chk("mid_nodone", done_cnt - d0, 32'd0);
        chk("mid_idle_start", {31'd0, bus.xf_start}, 32'd0);

`ifdef SEQ_TIMEOUT_EN
        // Point 0 never answered: times out after 15 WAIT cycles
        load(16'd1, 16'd1);
        load(16'd2, 16'd2);
        bus.batch_go = 1'b1;
        tick();
        bus.batch_go = 1'b0;
        chk("tmo_issue0", {31'd0, bus.xf_start}, 32'd1);
        for (int i = 0; i < 15; i++) tick();
        chk("tmo_still_wait", {31'd0, bus.xf_start}, 32'd0);
        chk("tmo_not_yet", {31'd0, bus.timeout_err}, 32'd0);
        tick();
        chk("tmo_flag", {31'd0, bus.timeout_err}, 32'd1);
        run_point(16'd2, 16'd2, 2, 1'b0);
        chk("tmo_done", {31'd0, bus.batch_done}, 32'd1);
        tick();
        chk("tmo_sticky", {31'd0, bus.timeout_err}, 32'd1);
        read_res(3'd0, 32'd0, "tmo_res0");
        read_res(3'd1, 32'h0003_0003, "tmo_res1");
        bus.batch_go = 1'b1;
        tick();
        bus.batch_go = 1'b0;
        chk("tmo_clear", {31'd0, bus.timeout_err}, 32'd0);
        tick();
`else
        // No timeout: WAIT holds indefinitely
        load(16'd1, 16'd1);
        bus.batch_go = 1'b1;
        tick();
        bus.batch_go = 1'b0;
        for (int i = 0; i < 25; i++) tick();
        chk("notmo_wait", {31'd0, bus.busy}, 32'd1);
        chk("notmo_flag", {31'd0, bus.timeout_err}, 32'd0);
        bus.xf_valid = 1'b1;
        bus.xf_combined = 32'h0002_0002;
        tick();
        bus.xf_valid = 1'b0;
        chk("notmo_done", {31'd0, bus.batch_done}, 32'd1);
        tick();
        read_res(3'd0, 32'h0002_0002, "notmo_res0");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
